// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA scan-out stage.
// Defaults describe 640x480@60 driven from a 320x240 indexed frame buffer.
package vga_pkg;

   localparam int H_TOTAL      = 800;
   localparam int V_TOTAL      = 525;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 751;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 491;

   localparam int FB_W  = 320;
   localparam int FB_H  = 240;
   localparam int FB_AW = 17;

   typedef enum logic {SWP_IDLE, SWP_PENDING} swap_state_t;

endpackage

// File: rtl/vga_scanout_sync_delay.sv
// N-stage shift register with a configurable reset value.
// It keeps the sync and blank controls in step with the palette mapper pipeline.
module sync_delay #(
   parameter int             W       = 1,
   parameter int             N       = 2,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stages [N];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < N; i++) stages[i] <= RST_VAL;
      end else begin
         stages[0] <= d;
         for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
      end
   end

   assign q = stages[N-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator and frame-buffer scan-out with 2x pixel/line doubling.
// Front/back bank swaps happen on the last clock of the visible frame.
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int FB_W     = vga_pkg::FB_W,
   parameter int FB_H     = vga_pkg::FB_H,
   parameter int FB_AW    = vga_pkg::FB_AW,
   parameter int PIPE_DLY = 3
) (
   input  logic           Clk,
   input  logic           Reset_n,
   output logic [FB_AW:0] fb_rd_addr,
   input  logic [7:0]     fb_rd_data,
   output logic [7:0]     draw_color,
   output logic           VGA_HS,
   output logic           VGA_VS,
   output logic           VGA_BLANK_N,
   input  logic           swap_req,
   output logic           swap_ack,
   output logic           front_sel,
   output logic           vblank,
   output logic           swap_state
);

   import vga_pkg::*;

   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_STOP    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_STOP    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0]       hc;
   logic [9:0]       vc;
   logic [FB_AW-1:0] line_base;
   swap_state_t      state;
   logic             swap_fired;
   logic             active;
   logic             active_d2;
   logic             hs_n;
   logic             vs_n;
   logic             end_line;
   logic             end_frame;
   logic [2:0]       sync_q;

   assign end_line  = (hc == H_LAST);
   assign end_frame = end_line && (vc == V_ACT_LAST);
   assign active    = (hc < H_ACT) && (vc < V_ACT);
   assign hs_n      = !((hc >= HS_START) && (hc <= HS_STOP));
   assign vs_n      = !((vc >= VS_START) && (vc <= VS_STOP));
   assign vblank    = (vc >= V_ACT);

   // line_base tracks (vc/2)*FB_W incrementally, stepping after each odd line.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hc        <= '0;
         vc        <= '0;
         line_base <= '0;
      end else if (end_line) begin
         hc <= '0;
         if (vc == V_LAST) begin
            vc        <= '0;
            line_base <= '0;
         end else begin
            vc <= vc + 10'd1;
            if (vc[0] && (vc < V_ACT_LAST)) line_base <= line_base + FB_AW'(FB_W);
         end
      end else begin
         hc <= hc + 10'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)    fb_rd_addr <= '0;
      else if (active) fb_rd_addr <= {front_sel, line_base + FB_AW'(hc[9:1])};
   end

   // A request landing on the swap clock itself is served without visiting PENDING.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= SWP_IDLE;
         front_sel  <= 1'b0;
         swap_fired <= 1'b0;
         swap_ack   <= 1'b0;
      end else begin
         swap_fired <= 1'b0;
         swap_ack   <= swap_fired;
         case (state)
            SWP_IDLE: begin
               if (swap_req) begin
                  if (end_frame) begin
                     front_sel  <= ~front_sel;
                     swap_fired <= 1'b1;
                  end else begin
                     state <= SWP_PENDING;
                  end
               end
            end
            SWP_PENDING: begin
               if (end_frame) begin
                  front_sel  <= ~front_sel;
                  swap_fired <= 1'b1;
                  state      <= SWP_IDLE;
               end
            end
            default: state <= SWP_IDLE;
         endcase
      end
   end

   assign swap_state = (state == SWP_PENDING);

   sync_delay #(.W(3), .N(PIPE_DLY), .RST_VAL(3'b110)) u_sync_dly (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .d       ({hs_n, vs_n, active}),
      .q       (sync_q)
   );

   assign VGA_HS      = sync_q[2];
   assign VGA_VS      = sync_q[1];
   assign VGA_BLANK_N = sync_q[0];

   sync_delay #(.W(1), .N(PIPE_DLY - 1), .RST_VAL(1'b0)) u_active_dly (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .d       (active),
      .q       (active_d2)
   );

   assign draw_color = active_d2 ? fb_rd_data : 8'd0;

endmodule
